// File: rtl/jt51_exp_arb_if.sv
// Request/response bundle between the exponent-ROM arbiter and its requesters.
interface jt51_exp_arb_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [5*NREQ-1:0] req_addr;
  logic [2*NREQ-1:0] req_bank;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic [1:0]        rsp_id;
  logic [9:0]        rsp_etf;
  logic [2:0]        rsp_etg;

  modport master (
    output req_valid, req_addr, req_bank,
    input  req_ready, rsp_valid, rsp_id, rsp_etf, rsp_etg
  );

  modport slave (
    input  req_valid, req_addr, req_bank,
    output req_ready, rsp_valid, rsp_id, rsp_etf, rsp_etg
  );
endinterface

// File: rtl/jt51_exp_arb.sv
// Round-robin arbiter and two-stage sequencer for the shared exponent ROM.
// Define JT51_EXPARB_FIXPRIO_EN for fixed priority (lowest index wins, no rr pointer).
module jt51_exp_arb #(
  parameter int unsigned NREQ = 2
) (
  input  logic           rst,
  input  logic           clk,
  input  logic           cen,
  jt51_exp_arb_if.slave  bus,
  output logic [4:0]     rom_addr,
  output logic [1:0]     rom_bank,
  input  logic [9:0]     rom_etf,
  input  logic [2:0]     rom_etg,
  output logic           busy
);

  logic [1:0] base;
  logic       gnt_found;
  logic [1:0] gnt_idx;
  logic       xfer;
  logic [4:0] sel_addr;
  logic [1:0] sel_bank;
  logic       s1_valid_q;
  logic [1:0] s1_id_q;
  logic       rsp_valid_q;
  logic [1:0] rsp_id_q;
  logic [9:0] rsp_etf_q;
  logic [2:0] rsp_etg_q;

  function automatic logic [1:0] wrap_idx(input logic [1:0] b, input int unsigned k);
    int unsigned s;
    s = {30'd0, b} + k;
    if (s >= NREQ) s = s - NREQ;
    return s[1:0];
  endfunction

  function automatic logic valid_at(input logic [NREQ-1:0] v, input logic [1:0] idx);
    logic r;
    r = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (idx == 2'(i)) r = v[i];
    end
    return r;
  endfunction

`ifdef JT51_EXPARB_FIXPRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] rr_q, rr_d;

  assign base = rr_q;
  assign rr_d = (gnt_idx == 2'(NREQ - 1)) ? 2'd0 : gnt_idx + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= 2'd0;
    end else if (xfer) begin
      rr_q <= rr_d;
    end
  end
`endif

  // Walk offsets from the far end so the nearest valid requester is assigned last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 2'd0;
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (valid_at(bus.req_valid, wrap_idx(base, k - 1))) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(base, k - 1);
      end
    end
  end

  assign xfer = cen & gnt_found;

  always_comb begin
    bus.req_ready = '0;
    sel_addr      = 5'd0;
    sel_bank      = 2'd0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      bus.req_ready[i] = xfer && (gnt_idx == 2'(i));
      if (gnt_idx == 2'(i)) begin
        sel_addr = bus.req_addr[5*i +: 5];
        sel_bank = bus.req_bank[2*i +: 2];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr    <= 5'd0;
      rom_bank    <= 2'd0;
      s1_valid_q  <= 1'b0;
      s1_id_q     <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 2'd0;
      rsp_etf_q   <= 10'd0;
      rsp_etg_q   <= 3'd0;
    end else if (cen) begin
      s1_valid_q  <= xfer;
      rsp_valid_q <= s1_valid_q;
      if (xfer) begin
        rom_addr <= sel_addr;
        rom_bank <= sel_bank;
        s1_id_q  <= gnt_idx;
      end
      if (s1_valid_q) begin
        rsp_id_q  <= s1_id_q;
        rsp_etf_q <= rom_etf;
        rsp_etg_q <= rom_etg;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_etf   = rsp_etf_q;
  assign bus.rsp_etg   = rsp_etg_q;
  assign busy          = s1_valid_q | rsp_valid_q;

endmodule

// File: tb/tb_jt51_exp_arb.sv
// Randomized bench for jt51_exp_arb against a queue-based reference model.
module tb_jt51_exp_arb;
  localparam int unsigned NREQ = 3;

  logic clk = 1'b0;
  logic rst;
  logic cen;
  logic [4:0] rom_addr;
  logic [1:0] rom_bank;
  logic [9:0] rom_etf;
  logic [2:0] rom_etg;
  logic       busy;

  always #5 clk = ~clk;

  jt51_exp_arb_if #(.NREQ(NREQ)) bus ();

  jt51_exp_arb #(.NREQ(NREQ)) dut (
    .rst      (rst),
    .clk      (clk),
    .cen      (cen),
    .bus      (bus),
    .rom_addr (rom_addr),
    .rom_bank (rom_bank),
    .rom_etf  (rom_etf),
    .rom_etg  (rom_etg),
    .busy     (busy)
  );

  logic [12:0] rom_tbl [128];
  assign {rom_etf, rom_etg} = rom_tbl[{rom_bank, rom_addr}];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester side: each pending request is held until it is granted.
  logic       pend   [NREQ];
  logic [4:0] p_addr [NREQ];
  logic [1:0] p_bank [NREQ];

  // Reference model state.
  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [12:0] data;
  } exp_t;
  exp_t        q[$];
  int          ncen;
  int          m_rr;
  logic [4:0]  m_addr;
  logic [1:0]  m_bank;
  logic        m_vld;
  logic [1:0]  m_id;
  logic [12:0] m_data;
  int          last_gnt;

  task automatic model_clear();
    q.delete();
    ncen   = 0;
    m_rr   = 0;
    m_addr = 5'd0;
    m_bank = 2'd0;
    m_vld  = 1'b0;
    m_id   = 2'd0;
    m_data = 13'd0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
  endtask

  task automatic drive_bus(input logic c);
    cen = c;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]      = pend[i];
      bus.req_addr[5*i +: 5] = p_addr[i];
      bus.req_bank[2*i +: 2] = p_bank[i];
    end
  endtask

  task automatic check_outputs();
    check_eq("rom_addr", 32'(rom_addr), 32'(m_addr));
    check_eq("rom_bank", 32'(rom_bank), 32'(m_bank));
    check_eq("rsp_valid", 32'(bus.rsp_valid), 32'(m_vld));
    check_eq("busy", 32'(busy), 32'(m_vld || (q.size() > 0)));
    if (m_vld) begin
      check_eq("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      check_eq("rsp_etf", 32'(bus.rsp_etf), 32'(m_data[12:3]));
      check_eq("rsp_etg", 32'(bus.rsp_etg), 32'(m_data[2:0]));
    end
  endtask

  // refill: 0 none, 1 random new requests, 2 every idle requester requests again
  task automatic cycle(input logic c, input int refill);
    int g;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    drive_bus(c);
    #4;
    g = -1;
    if (c) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_rr + k) % NREQ;
        if (pend[i] && g < 0) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    last_gnt = -1;
    for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) last_gnt = i;
    @(posedge clk);
    #1;
    if (c) begin
      ncen++;
      if (q.size() > 0 && q[0].due == ncen) begin
        m_vld  = 1'b1;
        m_id   = q[0].id;
        m_data = q[0].data;
        void'(q.pop_front());
      end else begin
        m_vld = 1'b0;
      end
      if (g >= 0) begin
        m_addr = p_addr[g];
        m_bank = p_bank[g];
        e.due  = ncen + 1;
        e.id   = 2'(g);
        e.data = rom_tbl[{p_bank[g], p_addr[g]}];
        q.push_back(e);
`ifndef JT51_EXPARB_FIXPRIO_EN
        m_rr = (g + 1) % NREQ;
`endif
        pend[g] = 1'b0;
      end
    end
    check_outputs();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && (refill == 2 || (refill == 1 && $urandom_range(0, 2) == 0))) begin
        pend[i]   = 1'b1;
        p_addr[i] = 5'($urandom);
        p_bank[i] = 2'($urandom);
      end
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_clear();
    drive_bus(1'b1);
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom_tbl[i] = 13'($urandom);
    rom_tbl[{2'd1, 5'd12}] = {10'h331, 3'b100};
    for (int i = 0; i < NREQ; i++) begin
      p_addr[i] = 5'd0;
      p_bank[i] = 2'd0;
    end
    last_gnt = -1;

    // Reset and idle
    do_reset(3);
    check_outputs();
    check_eq("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
    repeat (4) cycle(1'b1, 0);

    // Single lookup from requester 1
    pend[1] = 1'b1; p_addr[1] = 5'd12; p_bank[1] = 2'd1;
    cycle(1'b1, 0);
    check_eq("single_grant", 32'(last_gnt), 32'd1);
    check_eq("single_rom_addr", 32'(rom_addr), 32'd12);
    cycle(1'b1, 0);
    check_eq("single_etf", 32'(bus.rsp_etf), 32'h331);
    check_eq("single_etg", 32'(bus.rsp_etg), 32'h4);
    cycle(1'b1, 0);

    // All requesters continuously valid
    do_reset(1);
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1; p_addr[i] = 5'(i + 3); p_bank[i] = 2'(i);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b1, 2);
`ifdef JT51_EXPARB_FIXPRIO_EN
      check_eq("prio_order", 32'(last_gnt), 32'd0);
`else
      check_eq("rr_order", 32'(last_gnt), 32'(k % NREQ));
`endif
    end
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    repeat (3) cycle(1'b1, 0);

    // cen gating during a lookup
    pend[2] = 1'b1; p_addr[2] = 5'd7; p_bank[2] = 2'd3;
    cycle(1'b1, 0);
    cycle(1'b0, 0);
    cycle(1'b0, 0);
    cycle(1'b1, 0);
    check_eq("gated_rsp", 32'(bus.rsp_valid), 32'd1);
    cycle(1'b1, 0);

    // Mid-flight reset discards the in-flight lookup
    pend[1] = 1'b1; p_addr[1] = 5'd20; p_bank[1] = 2'd2;
    cycle(1'b1, 0);
    do_reset(1);
    check_outputs();
    repeat (3) cycle(1'b1, 0);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b1;
    cycle(1'b1, 0);
    check_eq("rr_after_reset", 32'(last_gnt), 32'd0);

    // Randomized traffic with random cen gaps
    for (int k = 0; k < 500; k++) cycle(($urandom_range(0, 3) != 0), 1);
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    repeat (4) cycle(1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/jt51_exp_arb.md
# jt51_exp_arb

Arbiter and sequencer for the shared exponential lookup ROM (attenuation → linear mantissa `etf` and shift `etg`). It accepts lookup requests from up to four requesters, such as the operator output path and the register/test readback path. It grants one request per clock-enable cycle, drives the ROM address and bank select from a register, and returns the ROM result tagged with the requester ID. It sits between the operator pipeline and the exponent ROM inside the JT51 core.

## Interface
Parameters:
- `NREQ`, 2 — number of requesters; legal values are 2 to 4.

Ports:
- `rst`  in  1 — asynchronous reset, active-high.
- `clk`  in  1 — single clock; the only clock in the block.
- `cen`  in  1 — clock enable. All state advances only when `cen`=1.
- `req_valid`  in  NREQ — request pending, one bit per requester.
- `req_addr`  in  5·NREQ — ROM address per requester. Requester *i* uses bits [5i+4:5i].
- `req_bank`  in  2·NREQ — ROM bank select (totalatten bits 7:6) per requester. Requester *i* uses bits [2i+1:2i].
- `req_ready`  out  NREQ — one-hot grant. Combinational from `req_valid` and the round-robin pointer.
- `rom_addr`  out  5 — registered address to the ROM.
- `rom_bank`  out  2 — registered bank select to the ROM.
- `rom_etf`  in  10 — ROM mantissa. Valid one `cen` cycle after `rom_addr`/`rom_bank` update.
- `rom_etg`  in  3 — ROM shift. Same timing as `rom_etf`.
- `rsp_valid`  out  1 — response strobe, high for one `cen` cycle.
- `rsp_id`  out  2 — index of the requester that receives the response.
- `rsp_etf`  out  10 — registered mantissa.
- `rsp_etg`  out  3 — registered shift.
- `busy`  out  1 — high when stage 1 or stage 2 holds a lookup.

## Operation
- Transfer rule: a request transfers on a `clk` edge with `cen`=1, `req_valid[i]`=1 and `req_ready[i]`=1.
- Requester hold rule: a requester keeps `req_valid`, `req_addr` and `req_bank` stable until the request transfers.
- Arbitration is round-robin. Pointer `rr` (2 bits, reset 0) gives the highest-priority index.
- Search order is `rr`, `rr`+1, … modulo NREQ. The first requester with `req_valid` set gets `req_ready`.
- After a transfer, `rr` becomes the granted index + 1, modulo NREQ.
- When `cen`=0, `req_ready` is 0 for all requesters.
- The pipeline has two stages and no stall:
  - S1 (issue): on transfer, `rom_addr`/`rom_bank` are loaded from the granted requester, `s1_valid` is set and `s1_id` records the index.
  - S2 (capture): on the next `cen` edge, if `s1_valid` is set, `rsp_etf`/`rsp_etg` are loaded from `rom_etf`/`rom_etg`, `rsp_id` is loaded from `s1_id` and `rsp_valid` is set.
- `rsp_valid` clears on any `cen` edge where `s1_valid` was 0.
- When no request transfers, `rom_addr` and `rom_bank` hold their previous values.
- There is no response backpressure. Consumers must accept `rsp_valid` whenever it is asserted.
- Throughput is one lookup per `cen` cycle, sustained.
- Indices ≥ NREQ are never granted. Their `req_valid` bits are ignored.
- `busy` = `s1_valid` OR `rsp_valid`.

## Timing
- Reset values: `rom_addr`=0, `rom_bank`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_etf`=0, `rsp_etg`=0, `rr`=0, `s1_valid`=0, `busy`=0.
- Latency: a request transferring at `cen` edge T produces `rsp_valid`=1 after `cen` edge T+1, with its data. That is exactly 2 `cen` cycles from request sampling to response.
- Gaps where `cen`=0 stretch latency in `clk` cycles only. No state changes while `cen`=0.
- Simultaneous requests: exactly one grant per `cen` cycle. With all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ−1,0,…
- Back-to-back: a new S1 issue and an S2 capture of the previous lookup happen on the same edge. Both proceed.
- Reset mid-operation: in-flight S1 and S2 contents are discarded. No `rsp_valid` is produced for them after reset releases.
- `req_ready` depends only on `req_valid`, `rr` and `cen`. It does not depend on ROM data, so it has no path from the ROM.

## Configuration
- `JT51_EXPARB_FIXPRIO_EN`, defined: fixed priority replaces round-robin. The lowest-index valid requester wins, and `rr` is not implemented. Requester 0 can then starve the others; this is intended so that the operator path always has precedence.
- Undefined (default): round-robin as described above.

## Test plan
- Reset and idle: assert `rst` for 3 cycles with `cen`=1 and no requests → all outputs zero. `busy`=0 and `rsp_valid` never asserts.
- Single lookup: `req_valid[1]`=1, addr=5'd12, bank=2'd1, ROM model returns etf=10'h331, etg=3'b100 → `req_ready[1]` on that edge. `rom_addr`=12 and `rom_bank`=1 after edge T. `rsp_valid`=1 with `rsp_id`=1, etf=10'h331, etg=3'b100 after edge T+1.
- Round-robin: NREQ=3, all three requesters valid for 6 `cen` cycles → grant order 0,1,2,0,1,2. Responses carry the same IDs in the same order, with 1 response per cycle.
- `cen` gating: `cen` toggles 1,0,0,1 during a lookup → the response appears on the second `cen`-high edge. Outputs stay frozen during `cen`=0.
- Mid-flight reset: issue a lookup, then pulse `rst` one cycle later → `rsp_valid` stays 0 and `rr`=0 after release.
- With `JT51_EXPARB_FIXPRIO_EN` defined: requesters 0 and 1 both valid continuously → requester 0 is granted every cycle and requester 1 gets no grant.
